// File: rtl/wb_stage.sv
// wb_stage: registered, handshaked write-back stage with load alignment and an EX bypass tap.
// Define WB_RETIRE_CNT_EN to build the retired-instruction counter; otherwise instret reads zero.
module wb_stage #(
   parameter int RFW  = 5,
   parameter int DW   = 32,
   parameter int IW   = 32,
   parameter int CNTW = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IW-1:0]   inst,
   input  logic [DW-1:0]   alu_res,
   input  logic [DW-1:0]   mem_rdata,
   input  logic [1:0]      addr_lo,
   input  logic [DW-1:0]   pc_plus4,
   input  logic            rf_ready,
   output logic            rf_we,
   output logic [RFW-1:0]  rf_waddr,
   output logic [DW-1:0]   rf_wdata,
   output logic            fwd_valid,
   output logic [RFW-1:0]  fwd_rd,
   output logic [DW-1:0]   fwd_data,
   output logic [CNTW-1:0] instret
);

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;

   // Halfword loads ignore addr_lo[0], so they shift by whole halfwords only.
   function automatic logic [DW-1:0] load_align(input logic [2:0]    f3,
                                                input logic [DW-1:0] rdata,
                                                input logic [1:0]    alo);
      logic [DW-1:0] byte_sh_s;
      logic [DW-1:0] half_sh_s;
      byte_sh_s = rdata >> {alo, 3'b000};
      half_sh_s = rdata >> {alo[1], 4'b0000};
      case (f3)
         3'b000:  load_align = DW'($signed(byte_sh_s[7:0]));
         3'b001:  load_align = DW'($signed(half_sh_s[15:0]));
         3'b010: begin
            if (DW == 32) load_align = rdata;
            else          load_align = DW'($signed(byte_sh_s[31:0]));
         end
         3'b100:  load_align = DW'(byte_sh_s[7:0]);
         3'b101:  load_align = DW'(half_sh_s[15:0]);
         default: load_align = {DW{1'b0}};
      endcase
   endfunction

   logic [4:0]     opcode_s;
   logic [2:0]     funct3_s;
   logic [RFW-1:0] rd_s;
   logic           wr_op_s;
   logic           we_next_s;
   logic [DW-1:0]  wdata_next_s;
   logic           accept_s;
   logic           drain_s;
   logic           unused_s;

   logic           held_valid_r;
   logic           held_we_r;
   logic [RFW-1:0] held_rd_r;
   logic [DW-1:0]  held_data_r;

   assign opcode_s = inst[6:2];
   assign funct3_s = inst[14:12];
   assign rd_s     = RFW'(inst[11:7]);
   assign unused_s = ^{inst[IW-1:15], inst[1:0]};

   // Decode the retiring instruction into write qualification and write-back data.
   always_comb begin
      wr_op_s      = 1'b0;
      wdata_next_s = alu_res;
      case (opcode_s)
         OPC_LOAD: begin
            wr_op_s      = 1'b1;
            wdata_next_s = load_align(funct3_s, mem_rdata, addr_lo);
         end
         OPC_JAL, OPC_JALR: begin
            wr_op_s      = 1'b1;
            wdata_next_s = pc_plus4;
         end
         OPC_OP_IMM, OPC_AUIPC, OPC_OP, OPC_LUI: begin
            wr_op_s      = 1'b1;
            wdata_next_s = alu_res;
         end
         default: begin
            wr_op_s      = 1'b0;
            wdata_next_s = alu_res;
         end
      endcase
   end

   assign we_next_s = wr_op_s && (rd_s != {RFW{1'b0}});
   assign in_ready  = !held_valid_r || rf_ready;
   assign accept_s  = in_valid && in_ready;
   assign drain_s   = held_valid_r && rf_ready;

   // Single-entry output register; a new accept may replace an entry draining on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         held_valid_r <= 1'b0;
         held_we_r    <= 1'b0;
         held_rd_r    <= {RFW{1'b0}};
         held_data_r  <= {DW{1'b0}};
      end else if (accept_s) begin
         held_valid_r <= 1'b1;
         held_we_r    <= we_next_s;
         held_rd_r    <= rd_s;
         held_data_r  <= wdata_next_s;
      end else if (drain_s) begin
         held_valid_r <= 1'b0;
         held_we_r    <= 1'b0;
      end
   end

   assign rf_we     = held_valid_r && held_we_r;
   assign rf_waddr  = held_rd_r;
   assign rf_wdata  = held_data_r;
   assign fwd_valid = held_valid_r && held_we_r;
   assign fwd_rd    = held_rd_r;
   assign fwd_data  = held_data_r;

`ifdef WB_RETIRE_CNT_EN
   logic [CNTW-1:0] instret_r;

   // Count every drained entry, writing or not; wraps naturally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instret_r <= {CNTW{1'b0}};
      end else if (drain_s) begin
         instret_r <= instret_r + CNTW'(1'b1);
      end
   end

   assign instret = instret_r;
`else
   assign instret = {CNTW{1'b0}};
`endif

endmodule
